// File: rtl/chip8_pkg.sv
// Shared types for the CHIP-8 keypad consumer logic.
//   key_idx_t    : 4-bit key index (0..15)
//   key_map_t    : 16-bit key bitmap, bit n = key n
//   wait_state_t : FX0A wait-for-key FSM states
//   NUM_KEYS     : number of keys on the hex keypad
package chip8_pkg;

    localparam int NUM_KEYS = 16;

    typedef logic [3:0]  key_idx_t;
    typedef logic [15:0] key_map_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLD,
        DONE
    } wait_state_t;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer.
// The debounced output flips only after the raw input has disagreed with it
// for DEBOUNCE_CYCLES consecutive clock edges; any agreeing sample restarts
// the count.
//   i_clock : system clock
//   i_reset : asynchronous active-high reset (output and counter clear)
//   i_raw   : raw key level from the scanner
//   o_db    : debounced key level
module key_debounce #(
    parameter int  DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_db
);

    logic [CNT_W-1:0] cnt;
    logic             db;

    // The counter tops out at DEBOUNCE_CYCLES-1: the edge that would take it
    // to DEBOUNCE_CYCLES flips the state and clears it instead, so it never wraps.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (i_raw == db) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            db  <= ~db;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_db = db;

endmodule

// File: rtl/chip8_key_ctrl.sv
// CHIP-8 keypad consumer: debounces the scanner bitmap, answers SKP/SKNP
// key queries and runs the FX0A wait-for-key handshake.
//   i_clock, i_reset   : clock / asynchronous active-high reset
//   i_keys             : raw 16-bit key bitmap from the scanner
//   o_keys_db          : debounced key bitmap
//   o_any_pressed      : OR of o_keys_db
//   i_query_key        : key index for SKP/SKNP
//   o_query_pressed    : o_keys_db[i_query_key], combinational
//   i_wait_req         : pulse, start an FX0A wait
//   i_wait_abort       : cancel an in-progress wait
//   o_wait_busy        : wait in progress (ARMED/HOLD/DONE)
//   o_wait_done        : one-cycle completion pulse
//   o_wait_key         : captured key, held until the next completion
module chip8_key_ctrl
    import chip8_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_keys,
    output logic [15:0] o_keys_db,
    output logic        o_any_pressed,
    input  logic [3:0]  i_query_key,
    output logic        o_query_pressed,
    input  logic        i_wait_req,
    input  logic        i_wait_abort,
    output logic        o_wait_busy,
    output logic        o_wait_done,
    output logic [3:0]  o_wait_key
);

    key_map_t    keys_db;
    key_map_t    keys_db_q;
    key_map_t    rise;
    wait_state_t state;
    key_idx_t    captured;
    logic        busy;
    logic        done;
    key_idx_t    wait_key;

    function automatic key_idx_t lowest_set(input key_map_t m);
        key_idx_t idx;
        idx = '0;
        for (int n = NUM_KEYS - 1; n >= 0; n--) begin
            if (m[n]) idx = key_idx_t'(n);
        end
        return idx;
    endfunction

    for (genvar n = 0; n < NUM_KEYS; n++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_clock(i_clock),
            .i_reset(i_reset),
            .i_raw  (i_keys[n]),
            .o_db   (keys_db[n])
        );
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            keys_db_q <= '0;
        end else begin
            keys_db_q <= keys_db;
        end
    end

    // Only fresh presses count: a key already held when the wait is armed
    // has db_q set, so it never produces a rise.
    assign rise = keys_db & ~keys_db_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            captured <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wait_key <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Abort takes priority over a simultaneous request.
                    if (i_wait_req && !i_wait_abort) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (i_wait_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (|rise) begin
                        captured <= lowest_set(rise);
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_wait_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!keys_db[captured]) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        wait_key <= captured;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_keys_db       = keys_db;
    assign o_any_pressed   = |keys_db;
    assign o_query_pressed = keys_db[i_query_key];
    assign o_wait_busy     = busy;
    assign o_wait_done     = done;
    assign o_wait_key      = wait_key;

endmodule
